// File: rtl/scroll_fb_ctrl.sv
// Scrolling frame-buffer controller: video read addressing plus one bin line written per scroll point.
// Define SCROLL_CLEAR_EN to zero the whole frame buffer after every reset before video starts.
module scroll_fb_ctrl #(
    parameter int H_VISIBLE   = 320,
    parameter int V_VISIBLE   = 240,
    parameter int SCROLL_LOG2 = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lower_blank,
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic              line_req,
    output logic              line_ack,
    output logic [8:0]        bin_addr,
    output logic              bin_rd_en,
    input  logic [DATA_W-1:0] bin_data,
    output logic [16:0]       fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              fb_we,
    output logic [7:0]        y_offset,
    output logic              pix_valid,
    output logic              overrun
);

    localparam logic [16:0] H17  = 17'(H_VISIBLE);
    localparam logic [8:0]  H9   = 9'(H_VISIBLE);
    localparam logic [8:0]  V9   = 9'(V_VISIBLE);
    localparam logic [7:0]  VMAX = 8'(V_VISIBLE - 1);
    localparam logic [SCROLL_LOG2-1:0] FC_ONE = SCROLL_LOG2'(1);

    typedef enum logic [1:0] {
        VIDEO      = 2'd0,
        WRITE_LINE = 2'd1,
        WAIT_VIDEO = 2'd2
`ifdef SCROLL_CLEAR_EN
        , CLEAR    = 2'd3
`endif
    } state_t;

`ifdef SCROLL_CLEAR_EN
    localparam state_t      RST_STATE = CLEAR;
    localparam logic [16:0] FB_WORDS  = 17'(H_VISIBLE * V_VISIBLE);
`else
    localparam state_t      RST_STATE = VIDEO;
`endif

    // Row wrap uses a 9-bit sum so y + y_offset can exceed 255 without aliasing.
    function automatic logic [8:0] wrap_row(input logic [7:0] row, input logic [7:0] offs);
        logic [8:0] sum;
        sum = {1'b0, row} + {1'b0, offs};
        return (sum >= V9) ? (sum - V9) : sum;
    endfunction

    function automatic logic [7:0] next_offset(input logic [7:0] offs);
        return (offs == VMAX) ? 8'd0 : (offs + 8'd1);
    endfunction

    state_t                 state, state_nxt;
    logic [8:0]             wcnt;
    logic [SCROLL_LOG2-1:0] frame_cnt;
    logic [16:0]            fb_addr_p1;
    logic                   wr_vld_p1;
    logic                   vid_load, frame_tick, line_done, ovr_set;
`ifdef SCROLL_CLEAR_EN
    logic [16:0]            ccnt;
    logic                   clr_load, clr_done, clr_vld_p1;

    assign clr_done = (ccnt == FB_WORDS);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= RST_STATE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            VIDEO:      if (lower_blank) state_nxt = ((&frame_cnt) && line_req) ? WRITE_LINE : WAIT_VIDEO;
            WRITE_LINE: if (wcnt == H9)  state_nxt = WAIT_VIDEO;
            WAIT_VIDEO: if (!lower_blank) state_nxt = VIDEO;
`ifdef SCROLL_CLEAR_EN
            CLEAR:      if (clr_done)    state_nxt = VIDEO;
`endif
            default:    state_nxt = RST_STATE;
        endcase
    end

    always_comb begin
        bin_rd_en  = 1'b0;
        bin_addr   = '0;
        vid_load   = 1'b0;
        frame_tick = 1'b0;
        line_done  = 1'b0;
        ovr_set    = 1'b0;
`ifdef SCROLL_CLEAR_EN
        clr_load   = 1'b0;
`endif
        case (state)
            VIDEO: begin
                vid_load   = 1'b1;
                frame_tick = lower_blank;
            end
            WRITE_LINE: begin
                ovr_set = !lower_blank;
                if (wcnt < H9) begin
                    bin_rd_en = 1'b1;
                    bin_addr  = wcnt;
                end else begin
                    line_done = 1'b1;
                end
            end
`ifdef SCROLL_CLEAR_EN
            CLEAR: clr_load = !clr_done;
`endif
            default: ;
        endcase
    end

    // p0 -> p1: address/valid registered; bin_data arrives in the same cycle as wr_vld_p1
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fb_addr_p1 <= '0;
            wr_vld_p1  <= 1'b0;
            pix_valid  <= 1'b0;
            line_ack   <= 1'b0;
            wcnt       <= '0;
            frame_cnt  <= '0;
            y_offset   <= '0;
            overrun    <= 1'b0;
`ifdef SCROLL_CLEAR_EN
            ccnt       <= '0;
            clr_vld_p1 <= 1'b0;
`endif
        end else begin
            wr_vld_p1 <= bin_rd_en;
            pix_valid <= vid_load && !lower_blank;
            line_ack  <= line_done;
            wcnt      <= bin_rd_en ? (wcnt + 9'd1) : 9'd0;
            if (vid_load)
                fb_addr_p1 <= 17'(x) + 17'(wrap_row(y, y_offset)) * H17;
            else if (bin_rd_en)
                fb_addr_p1 <= 17'(y_offset) * H17 + 17'(wcnt);
`ifdef SCROLL_CLEAR_EN
            else if (clr_load)
                fb_addr_p1 <= ccnt;
            clr_vld_p1 <= clr_load;
            if (clr_load) ccnt <= ccnt + 17'd1;
`endif
            if (frame_tick) frame_cnt <= frame_cnt + FC_ONE;
            if (line_done)  y_offset  <= next_offset(y_offset);
            if (ovr_set)    overrun   <= 1'b1;
        end
    end

    assign fb_addr  = fb_addr_p1;
    assign fb_wdata = wr_vld_p1 ? bin_data : '0;
`ifdef SCROLL_CLEAR_EN
    assign fb_we    = wr_vld_p1 | clr_vld_p1;
`else
    assign fb_we    = wr_vld_p1;
`endif

endmodule
